// File: rtl/usb_pkg.sv
// Shared USB definitions: PID encodings, SYNC pattern, CRC16 constants and
// the transmit sequencer state type.
package usb_pkg;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_t;

    // Serialized LSB-first this becomes KJKJKJKK on the wire.
    localparam logic [7:0]  USB_SYNC_BYTE  = 8'h80;

    // Reflected CRC16 (x^16+x^15+x^2+1); residual is the reflected 16'h800D.
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY     = 16'hA001;
    localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_PID,
        TX_DATA,
        TX_CRC_LO,
        TX_CRC_HI,
        TX_EOP,
        TX_WAIT_EOP
    } tx_state_t;

    // A device may only originate handshakes and data packets.
    function automatic logic tx_pid_legal(input logic [3:0] pid);
        case (pid)
            PID_ACK, PID_NAK, PID_STALL, PID_DATA0, PID_DATA1: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Data PIDs share 2'b11 in the low bits, handshakes share 2'b10.
    function automatic logic pid_is_data(input logic [3:0] pid);
        return (pid[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// One-byte combinational update of the reflected USB CRC16.
// Shared between the transmit sequencer and the receive-side checker.
module usb_crc16
    import usb_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    // Fold the byte into the low half, then shift out eight bits LSB-first.
    always_comb begin
        crc_out = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC16_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/usb_tx_packet_fsm.sv
// Device-side USB transmit packet sequencer: SYNC, PID, payload, CRC16, EOP.
//
// state       | meaning
// ------------+------------------------------------------------------------
// TX_IDLE     | waiting for tx_start; illegal PID flagged here
// TX_SYNC     | presenting SYNC byte to serializer
// TX_PID      | presenting {~pid, pid}
// TX_DATA     | payload passes straight through from endpoint buffer
// TX_CRC_LO   | presenting ~crc[7:0]
// TX_CRC_HI   | presenting ~crc[15:8]
// TX_EOP      | send_eop pulse
// TX_WAIT_EOP | waiting for serializer to finish EOP
module usb_tx_packet_fsm
    import usb_pkg::*;
#(
    parameter int         MAX_PAYLOAD = 64,
    parameter logic [7:0] SYNC_BYTE   = USB_SYNC_BYTE
)
(
    input  logic       clk,
    input  logic       RST,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_zlp,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_data_last,
    output logic       tx_data_ready,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    input  logic       tx_byte_ready,
    output logic       send_eop,
    input  logic       eop_done,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    localparam logic [6:0] LAST_IDX = 7'(MAX_PAYLOAD - 1);

    tx_state_t   state;
    logic [3:0]  pid_q;
    logic        zlp_q;
    logic [15:0] crc_q;
    logic [15:0] crc_next;
    logic [6:0]  byte_cnt;
    logic [7:0]  byte_q;
    logic        byte_valid_q;

    usb_crc16 u_crc (
        .crc_in  (crc_q),
        .data    (tx_data),
        .crc_out (crc_next)
    );

    // Payload is not registered so the endpoint sees back-pressure directly.
    assign tx_byte       = (state == TX_DATA) ? tx_data       : byte_q;
    assign tx_byte_valid = (state == TX_DATA) ? tx_data_valid : byte_valid_q;
    assign tx_data_ready = (state == TX_DATA) & tx_data_valid & tx_byte_ready;

    // Packet sequencing with registered byte, status and pulse outputs.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= TX_IDLE;
            pid_q        <= 4'h0;
            zlp_q        <= 1'b0;
            crc_q        <= CRC16_INIT;
            byte_cnt     <= 7'd0;
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
            send_eop     <= 1'b0;
            busy         <= 1'b0;
            tx_done      <= 1'b0;
            tx_err       <= 1'b0;
        end else begin
            send_eop <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (tx_start) begin
                        if (tx_pid_legal(tx_pid)) begin
                            pid_q        <= tx_pid;
                            zlp_q        <= tx_zlp;
                            crc_q        <= CRC16_INIT;
                            byte_cnt     <= 7'd0;
                            byte_q       <= SYNC_BYTE;
                            byte_valid_q <= 1'b1;
                            busy         <= 1'b1;
                            state        <= TX_SYNC;
                        end else begin
                            tx_err <= 1'b1;
                        end
                    end
                end
                TX_SYNC: begin
                    if (tx_byte_ready) begin
                        byte_q <= {~pid_q, pid_q};
                        state  <= TX_PID;
                    end
                end
                TX_PID: begin
                    if (tx_byte_ready) begin
                        if (!pid_is_data(pid_q)) begin
                            byte_q       <= 8'h00;
                            byte_valid_q <= 1'b0;
                            send_eop     <= 1'b1;
                            state        <= TX_EOP;
                        end else if (zlp_q) begin
                            byte_q <= ~crc_q[7:0];
                            state  <= TX_CRC_LO;
                        end else begin
                            byte_q       <= 8'h00;
                            byte_valid_q <= 1'b0;
                            state        <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_byte_ready) begin
                        if (tx_data_valid) begin
                            crc_q    <= crc_next;
                            byte_cnt <= byte_cnt + 7'd1;
                            // A full buffer without last is closed out as if last.
                            if (tx_data_last || byte_cnt == LAST_IDX) begin
                                tx_err       <= ~tx_data_last;
                                byte_q       <= ~crc_next[7:0];
                                byte_valid_q <= 1'b1;
                                state        <= TX_CRC_LO;
                            end
                        end else begin
                            // Underrun: abort without CRC so the host discards it.
                            tx_err   <= 1'b1;
                            send_eop <= 1'b1;
                            state    <= TX_EOP;
                        end
                    end
                end
                TX_CRC_LO: begin
                    if (tx_byte_ready) begin
                        byte_q <= ~crc_q[15:8];
                        state  <= TX_CRC_HI;
                    end
                end
                TX_CRC_HI: begin
                    if (tx_byte_ready) begin
                        byte_q       <= 8'h00;
                        byte_valid_q <= 1'b0;
                        send_eop     <= 1'b1;
                        state        <= TX_EOP;
                    end
                end
                TX_EOP: begin
                    state <= TX_WAIT_EOP;
                end
                TX_WAIT_EOP: begin
                    if (eop_done) begin
                        tx_done <= 1'b1;
                        busy    <= 1'b0;
                        state   <= TX_IDLE;
                    end
                end
                default: begin
                    byte_valid_q <= 1'b0;
                    busy         <= 1'b0;
                    state        <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_packet_fsm.sv
// Bench for the USB transmit sequencer: a serializer/endpoint model drives
// the handshakes and a packet-level reference model predicts the byte stream.
module tb_usb_tx_packet_fsm;

    logic       clk = 1'b0;
    logic       RST;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic       tx_zlp;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_last;
    logic       tx_data_ready;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       tx_byte_ready;
    logic       send_eop;
    logic       eop_done;
    logic       busy;
    logic       tx_done;
    logic       tx_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pl [0:127];
    logic [3:0] legal [5] = '{4'b0010, 4'b1010, 4'b1110, 4'b0011, 4'b1011};

    usb_tx_packet_fsm #(.MAX_PAYLOAD(64), .SYNC_BYTE(8'h80)) dut (
        .clk           (clk),
        .RST           (RST),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_zlp        (tx_zlp),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_last  (tx_data_last),
        .tx_data_ready (tx_data_ready),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_ready (tx_byte_ready),
        .send_eop      (send_eop),
        .eop_done      (eop_done),
        .busy          (busy),
        .tx_done       (tx_done),
        .tx_err        (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial USB CRC16 over a whole message (init all-ones, reflected poly).
    function automatic logic [15:0] crc_bits(input logic [7:0] q[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return c;
    endfunction

    task automatic idle_inputs();
        tx_start      = 1'b0;
        tx_pid        = 4'h0;
        tx_zlp        = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        tx_data_last  = 1'b0;
        tx_byte_ready = 1'b0;
        eop_done      = 1'b0;
    endtask

    // Entered and left just after a rising edge. underrun_k < 0 means no underrun.
    task automatic send_packet(input logic [3:0] pid, input logic zlp, input int n,
                               input logic give_last, input int underrun_k,
                               input logic rand_ready, input string name);
        logic [7:0]  exp_q[$];
        logic [7:0]  got_q[$];
        logic [7:0]  crc_q[$];
        logic [15:0] c;
        logic [7:0]  pbyte;
        logic        pend, consumed, done, stray_ok, busy_at_done;
        int          eff, exp_consumed, exp_err;
        int          idx, cyc, errs, eops, dones, viol, first_v, last_acc, first_eop, eop_timer;

        exp_q.push_back(8'h80);
        exp_q.push_back({~pid, pid});
        exp_err      = 0;
        exp_consumed = 0;
        if (pid[1:0] == 2'b11 && !zlp) begin
            if (underrun_k >= 0)          eff = underrun_k;
            else if (give_last && n <= 64) eff = n;
            else                           eff = 64;
            for (int i = 0; i < eff; i++) begin
                exp_q.push_back(pl[i]);
                crc_q.push_back(pl[i]);
            end
            exp_consumed = eff;
            if (underrun_k >= 0) begin
                exp_err = 1;
            end else begin
                c = crc_bits(crc_q);
                exp_q.push_back(~c[7:0]);
                exp_q.push_back(~c[15:8]);
                if (!(give_last && n <= 64)) exp_err = 1;
            end
        end else if (pid[1:0] == 2'b11) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
        end

        idx = 0; cyc = 0; errs = 0; eops = 0; dones = 0; viol = 0;
        first_v = -1; last_acc = -1; first_eop = -1; eop_timer = -1;
        pend = 1'b0; pbyte = 8'h00; done = 1'b0; stray_ok = 1'b1; busy_at_done = 1'b1;
        tx_start = 1'b1;
        tx_pid   = pid;
        tx_zlp   = zlp;

        while (!done && cyc < 2000) begin
            tx_byte_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            if ((underrun_k >= 0 && idx >= underrun_k) || idx >= n) tx_data_valid = 1'b0;
            else tx_data_valid = 1'b1;
            tx_data      = pl[idx % 128];
            tx_data_last = give_last && (idx == n - 1);
            if (eop_timer == 0) begin
                eop_done  = 1'b1;
                eop_timer = -1;
                stray_ok  = 1'b0;
            end else begin
                eop_done = 1'b0;
                if (eop_timer > 0) eop_timer--;
            end
            if (cyc >= 1) begin
                tx_start = stray_ok && (first_eop < 0) && ($urandom % 6 == 0);
                tx_pid   = ($urandom % 2 == 0) ? 4'b1001 : 4'b0010;
            end

            @(negedge clk);
            if (tx_byte_valid && first_v < 0) first_v = cyc;
            if (pend && (!tx_byte_valid || tx_byte !== pbyte)) viol++;
            pend  = tx_byte_valid && !tx_byte_ready;
            pbyte = tx_byte;
            if (tx_byte_valid && tx_byte_ready) begin
                got_q.push_back(tx_byte);
                last_acc = cyc;
            end
            consumed = tx_data_ready;
            if (tx_data_ready && !(tx_data_valid && tx_byte_ready)) viol++;
            if (send_eop) begin
                eops++;
                if (first_eop < 0) begin
                    first_eop = cyc;
                    eop_timer = $urandom_range(0, 3);
                end
            end
            if (tx_err) errs++;
            if (tx_done) begin
                dones++;
                done         = 1'b1;
                busy_at_done = busy;
            end
            @(posedge clk);
            #1;
            if (consumed) idx++;
            cyc++;
        end
        idle_inputs();

        check({name, ":done"}, dones, 1);
        check({name, ":busy_after"}, 32'(busy_at_done), 0);
        check({name, ":nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s:byte%0d", name, i), got_q[i], exp_q[i]);
        end
        check({name, ":consumed"}, idx, exp_consumed);
        check({name, ":err"}, errs, exp_err);
        check({name, ":eop_pulses"}, eops, 1);
        check({name, ":stable"}, viol, 0);
        check({name, ":first_valid"}, first_v, 1);
        if (underrun_k < 0) check({name, ":eop_latency"}, first_eop - last_acc, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int quiet;
        idle_inputs();
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst:busy", busy, 0);
        check("rst:outs", {tx_byte_valid, tx_data_ready, send_eop, tx_done, tx_err}, 0);
        check("rst:byte", tx_byte, 0);
        RST = 1'b0;
        @(posedge clk);
        #1;

        send_packet(4'b0010, 1'b0, 0, 1'b1, -1, 1'b0, "ack");
        send_packet(4'b0011, 1'b1, 0, 1'b1, -1, 1'b0, "zlp");
        for (int i = 0; i < 9; i++) pl[i] = 8'h31 + 8'(i);
        send_packet(4'b1011, 1'b0, 9, 1'b1, -1, 1'b0, "d1_123");
        send_packet(4'b1011, 1'b0, 9, 1'b1, -1, 1'b1, "d1_bp");

        // Illegal PID from IDLE.
        tx_start = 1'b1;
        tx_pid   = 4'b1001;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        @(negedge clk);
        check("ill:err", tx_err, 1);
        check("ill:busy", busy, 0);
        @(negedge clk);
        check("ill:err_pulse", tx_err, 0);
        check("ill:busy2", busy, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
        send_packet(4'b0011, 1'b0, 10, 1'b1, 2, 1'b1, "underrun");
        for (int i = 0; i < 70; i++) pl[i] = 8'($urandom);
        send_packet(4'b1011, 1'b0, 70, 1'b0, -1, 1'b1, "overlen");
        send_packet(4'b0011, 1'b0, 64, 1'b1, -1, 1'b0, "max64");

        // Reset in the middle of the payload.
        tx_pid        = 4'b1011;
        tx_start      = 1'b1;
        tx_byte_ready = 1'b1;
        tx_data_valid = 1'b1;
        tx_data       = 8'h31;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid:in_data", tx_data_ready, 1);
        RST = 1'b1;
        #1;
        check("rst_mid:busy", busy, 0);
        check("rst_mid:valid", tx_byte_valid, 0);
        check("rst_mid:eop", send_eop, 0);
        @(posedge clk);
        #1;
        RST = 1'b0;
        idle_inputs();
        quiet = 0;
        repeat (5) begin
            @(negedge clk);
            if (send_eop || tx_done || tx_err || busy) quiet++;
        end
        check("rst_mid:quiet", quiet, 0);
        @(posedge clk);
        #1;
        send_packet(4'b1010, 1'b0, 0, 1'b1, -1, 1'b0, "nak_after_rst");

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) pl[i] = 8'($urandom);
            send_packet(legal[$urandom % 5], 1'($urandom % 2), n, 1'b1, -1, 1'b1,
                        $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
